// File: rtl/adaptive_filter_pkg.sv
// Shared types and helpers for the adaptive filter datapath: lane mode encoding,
// width defaults, the accumulator FSM states and the saturating add.
package adaptive_filter_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int NTAPS_DEF  = 8;

    typedef enum logic {
        MODE_4x2 = 1'b0,
        MODE_8x1 = 1'b1
    } mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Returns {overflow, clamped_sum}; the sum is clamped to 2^acc_w-1.
    function automatic logic [32:0] sat_add(input logic [31:0] acc,
                                            input logic [31:0] v,
                                            input int          acc_w);
        logic [32:0] sum;
        logic [32:0] max_val;
        max_val = (33'd1 << acc_w) - 33'd1;
        sum     = {1'b0, acc} + {1'b0, v};
        if (sum > max_val) begin
            sat_add = {1'b1, max_val[31:0]};
        end else begin
            sat_add = {1'b0, sum[31:0]};
        end
    endfunction

endpackage

// File: rtl/carry_resolve_acc_if.sv
// Beat input channel and result output channel of the carry resolver/accumulator.
interface carry_resolve_acc_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_sum;
    logic              in_cc1;
    logic              in_cc2;
    logic              in_mode;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_lo;
    logic [ACC_W-1:0]  out_hi;
    logic [1:0]        out_ovf;
    logic              out_merr;

    modport slave (
        input  in_valid, in_sum, in_cc1, in_cc2, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_lo, out_hi, out_ovf, out_merr
    );

    modport master (
        output in_valid, in_sum, in_cc1, in_cc2, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_lo, out_hi, out_ovf, out_merr
    );
endinterface

// File: rtl/carry_beat_decode.sv
// Resolves one beat's partial sum and carry pair into per-lane values.
// 8-bit mode: cc1/cc2 weigh 2^DATA_W and 2^(DATA_W+1); 4-bit mode: each carry tops its own nibble.
module carry_beat_decode
    import adaptive_filter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] sum,
    input  logic              cc1,
    input  logic              cc2,
    input  logic              mode,
    output logic [DATA_W+1:0] v0,
    output logic [DATA_W+1:0] v1
);
    localparam int HALF = DATA_W / 2;

    always_comb begin
        v0 = '0;
        v1 = '0;
        if (mode == MODE_8x1) begin
            v0 = {cc2, cc1, sum};
        end else begin
            v0[HALF:0] = {cc1, sum[HALF-1:0]};
            v1[HALF:0] = {cc2, sum[DATA_W-1:HALF]};
        end
    end

endmodule

// File: rtl/carry_resolve_acc.sv
// Accumulates resolved carry-computator beats over a frame of taps into saturating lane
// totals and hands the frame result downstream through a valid/ready register stage.
module carry_resolve_acc
    import adaptive_filter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int NTAPS  = NTAPS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    carry_resolve_acc_if.slave   bus
);
    localparam int V_W   = DATA_W + 2;
    localparam int CNT_W = $clog2(NTAPS + 1);

    state_t                state_reg, state_next;
    logic                  mode_reg, mode_next;
    logic                  merr_reg, merr_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [1:0][ACC_W-1:0] acc_reg, acc_next;
    logic [1:0]            ovf_reg, ovf_next;

    logic                  out_valid_reg;
    logic [ACC_W-1:0]      out_lo_reg;
    logic [ACC_W-1:0]      out_hi_reg;
    logic [1:0]            out_ovf_reg;
    logic                  out_merr_reg;

    logic                  in_ready;
    logic                  accept;
    logic                  first_beat;
    logic                  beat_mode;
    logic                  beat_merr;
    logic                  close_frame;
    logic                  out_load;
    logic [CNT_W-1:0]      cnt_new;
    logic [1:0][V_W-1:0]   beat_v;
    logic [1:0][ACC_W-1:0] base_acc;
    logic [1:0][ACC_W-1:0] sum_acc;
    logic [1:0]            base_ovf;
    logic [1:0]            sum_ovf;

    assign in_ready    = ~out_valid_reg | bus.out_ready;
    assign accept      = bus.in_valid & in_ready;
    assign first_beat  = (state_reg == IDLE);
    // Mid-frame beats are decoded in the mode latched by the frame's first beat.
    assign beat_mode   = first_beat ? bus.in_mode : mode_reg;
    assign beat_merr   = ~first_beat & (merr_reg | (bus.in_mode != mode_reg));
    assign cnt_new     = first_beat ? CNT_W'(1) : cnt_reg + 1'b1;
    assign close_frame = bus.in_last | (cnt_new == CNT_W'(NTAPS));

    carry_beat_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .sum  (bus.in_sum),
        .cc1  (bus.in_cc1),
        .cc2  (bus.in_cc2),
        .mode (beat_mode),
        .v0   (beat_v[0]),
        .v1   (beat_v[1])
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [32:0] sat_w;
            assign base_acc[gi] = first_beat ? '0 : acc_reg[gi];
            assign base_ovf[gi] = ~first_beat & ovf_reg[gi];
            assign sat_w        = sat_add(32'(base_acc[gi]), 32'(beat_v[gi]), ACC_W);
            assign sum_acc[gi]  = sat_w[ACC_W-1:0];
            // Bits above ACC_W are zero whenever the clamp holds, so folding them in is harmless.
            assign sum_ovf[gi]  = sat_w[32] | (|sat_w[31:ACC_W]) | base_ovf[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            mode_reg  <= 1'b0;
            merr_reg  <= 1'b0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            ovf_reg   <= '0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            merr_reg  <= merr_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        merr_next  = merr_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        out_load   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    mode_next = bus.in_mode;
                    if (close_frame) begin
                        out_load = 1'b1;
                    end else begin
                        state_next = ACCUM;
                        cnt_next   = cnt_new;
                        acc_next   = sum_acc;
                        ovf_next   = sum_ovf;
                        merr_next  = 1'b0;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (close_frame) begin
                        out_load = 1'b1;
                    end else begin
                        cnt_next  = cnt_new;
                        acc_next  = sum_acc;
                        ovf_next  = sum_ovf;
                        merr_next = beat_merr;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (out_load) begin
            state_next = IDLE;
            cnt_next   = '0;
            acc_next   = '0;
            ovf_next   = '0;
            merr_next  = 1'b0;
        end
    end

    // A closing beat can only be accepted when the previous result leaves this cycle,
    // so loading here replaces it without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_lo_reg    <= '0;
            out_hi_reg    <= '0;
            out_ovf_reg   <= '0;
            out_merr_reg  <= 1'b0;
        end else if (out_load) begin
            out_valid_reg <= 1'b1;
            out_lo_reg    <= sum_acc[0];
            out_hi_reg    <= sum_acc[1];
            out_ovf_reg   <= sum_ovf;
            out_merr_reg  <= beat_merr;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_lo    = out_lo_reg;
    assign bus.out_hi    = out_hi_reg;
    assign bus.out_ovf   = out_ovf_reg;
    assign bus.out_merr  = out_merr_reg;

endmodule

// File: tb/tb_carry_resolve_acc.sv
// Scoreboard bench: two accumulators (16-bit and 10-bit lanes) share one beat stream;
// a frame-level model queues expected results and a monitor checks each handshake.
module tb_carry_resolve_acc;
    localparam int NTAPS = 8;

    typedef struct {
        int lo;
        int hi;
        int ovf;
        int merr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    carry_resolve_acc_if #(.DATA_W(8), .ACC_W(16)) bus16 ();
    carry_resolve_acc_if #(.DATA_W(8), .ACC_W(10)) bus10 ();

    carry_resolve_acc #(.DATA_W(8), .ACC_W(16), .NTAPS(NTAPS)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    carry_resolve_acc #(.DATA_W(8), .ACC_W(10), .NTAPS(NTAPS)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (bus10)
    );

    assign bus10.in_valid  = bus16.in_valid;
    assign bus10.in_sum    = bus16.in_sum;
    assign bus10.in_cc1    = bus16.in_cc1;
    assign bus10.in_cc2    = bus16.in_cc2;
    assign bus10.in_mode   = bus16.in_mode;
    assign bus10.in_last   = bus16.in_last;
    assign bus10.out_ready = bus16.out_ready;

    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;   // 0 always ready, 1 random, 2 held off
    exp_t q16[$];
    exp_t q10[$];

    // Frame-level reference: lane totals are summed exactly, then clamped per width.
    bit   m_active = 0;
    int   m_mode, m_merr, m_cnt, m_sum0, m_sum1;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic exp_t make_exp(input int s0, input int s1, input int w, input int merr);
        exp_t e;
        int   mx;
        mx     = (1 << w) - 1;
        e.lo   = (s0 > mx) ? mx : s0;
        e.hi   = (s1 > mx) ? mx : s1;
        e.ovf  = ((s0 > mx) ? 1 : 0) + ((s1 > mx) ? 2 : 0);
        e.merr = merr;
        return e;
    endfunction

    task automatic model_accept(input int sum, input int cc1, input int cc2,
                                input int mode, input int last);
        if (!m_active) begin
            m_active = 1;
            m_mode   = mode;
            m_merr   = 0;
            m_cnt    = 0;
            m_sum0   = 0;
            m_sum1   = 0;
        end else if (mode != m_mode) begin
            m_merr = 1;
        end
        if (m_mode == 1) begin
            m_sum0 += sum + 256 * cc1 + 512 * cc2;
        end else begin
            m_sum0 += (sum % 16) + 16 * cc1;
            m_sum1 += (sum / 16) + 16 * cc2;
        end
        m_cnt++;
        if (last != 0 || m_cnt == NTAPS) begin
            q16.push_back(make_exp(m_sum0, m_sum1, 16, m_merr));
            q10.push_back(make_exp(m_sum0, m_sum1, 10, m_merr));
            m_active = 0;
        end
    endtask

    task automatic send_beat(input int sum, input int cc1, input int cc2,
                             input int mode, input int last);
        bit done = 0;
        bit acc;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            bus16.in_valid = 1'b1;
            bus16.in_sum   = 8'(sum);
            bus16.in_cc1   = 1'(cc1);
            bus16.in_cc2   = 1'(cc2);
            bus16.in_mode  = 1'(mode);
            bus16.in_last  = 1'(last);
            #1;
            acc = bus16.in_ready;
            @(posedge clk);
            if (acc) begin
                model_accept(sum, cc1, cc2, mode, last);
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got no acceptance expected one within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus16.in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus16.in_valid = 1'b0;
        rst = 1'b1;
        #3;
        // Whatever sits in the output register is gone after this edge.
        if (bus16.out_valid && q16.size() > 0) void'(q16.pop_front());
        if (bus10.out_valid && q10.size() > 0) void'(q10.pop_front());
        m_active = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid16", int'(bus16.out_valid), 0);
        check("rst_lo16", int'(bus16.out_lo), 0);
        check("rst_hi16", int'(bus16.out_hi), 0);
        check("rst_ovf16", int'(bus16.out_ovf), 0);
        check("rst_merr16", int'(bus16.out_merr), 0);
        check("rst_valid10", int'(bus10.out_valid), 0);
    endtask

    task automatic cmp_res(input string tag, input int lo, input int hi, input int ovf,
                           input int merr, input exp_t e);
        $display("txn %s lo=%0d hi=%0d ovf=%0d merr=%0d (exp %0d %0d %0d %0d)",
                 tag, lo, hi, ovf, merr, e.lo, e.hi, e.ovf, e.merr);
        check({tag, "_lo"}, lo, e.lo);
        check({tag, "_hi"}, hi, e.hi);
        check({tag, "_ovf"}, ovf, e.ovf);
        check({tag, "_merr"}, merr, e.merr);
    endtask

    // out_ready driver
    initial begin
        bus16.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       bus16.out_ready = 1'b1;
                1:       bus16.out_ready = ($urandom_range(0, 3) != 0);
                default: bus16.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor
    initial begin
        bit   prev_stall = 0;
        int   p_lo = 0, p_hi = 0, p_ovf = 0, p_merr = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 0;
                continue;
            end
            check("in_ready", int'(bus16.in_ready),
                  int'(!bus16.out_valid || bus16.out_ready));
            if (prev_stall) begin
                check("stall_valid", int'(bus16.out_valid), 1);
                check("stall_lo", int'(bus16.out_lo), p_lo);
                check("stall_hi", int'(bus16.out_hi), p_hi);
                check("stall_ovf", int'(bus16.out_ovf), p_ovf);
                check("stall_merr", int'(bus16.out_merr), p_merr);
            end
            if (bus16.out_valid && bus16.out_ready) begin
                if (q16.size() == 0) begin
                    check("w16_unexpected_result", 1, 0);
                end else begin
                    e = q16.pop_front();
                    cmp_res("w16", int'(bus16.out_lo), int'(bus16.out_hi),
                            int'(bus16.out_ovf), int'(bus16.out_merr), e);
                end
            end
            if (bus10.out_valid && bus10.out_ready) begin
                if (q10.size() == 0) begin
                    check("w10_unexpected_result", 1, 0);
                end else begin
                    e = q10.pop_front();
                    cmp_res("w10", int'(bus10.out_lo), int'(bus10.out_hi),
                            int'(bus10.out_ovf), int'(bus10.out_merr), e);
                end
            end
            prev_stall = bus16.out_valid && !bus16.out_ready;
            p_lo   = int'(bus16.out_lo);
            p_hi   = int'(bus16.out_hi);
            p_ovf  = int'(bus16.out_ovf);
            p_merr = int'(bus16.out_merr);
        end
    end

    // Stimulus
    initial begin
        bus16.in_valid = 1'b0;
        bus16.in_sum   = '0;
        bus16.in_cc1   = 1'b0;
        bus16.in_cc2   = 1'b0;
        bus16.in_mode  = 1'b0;
        bus16.in_last  = 1'b0;
        do_reset();

        // mode 1, two beats resolving to 0x1FF and 0x201
        send_beat(8'hFF, 1, 0, 1, 0);
        send_beat(8'h01, 0, 1, 1, 1);
        idle(2);

        // mode 0, three beats of 0xA5 with both carries
        for (int i = 0; i < 3; i++) send_beat(8'hA5, 1, 1, 0, (i == 2) ? 1 : 0);
        idle(2);

        // frame auto-closes at NTAPS; the ninth beat starts a fresh frame
        for (int i = 0; i < 9; i++) send_beat(0, 0, 0, 1, (i == 8) ? 1 : 0);
        idle(2);

        // two full-scale beats saturate the 10-bit lane
        send_beat(8'hFF, 1, 1, 1, 0);
        send_beat(8'hFF, 1, 1, 1, 1);
        idle(2);

        // stalled result, then a one-beat frame presented while still stalled
        ready_mode = 2;
        send_beat(8'h12, 1, 0, 0, 1);
        idle(6);
        fork
            begin
                repeat (2) @(negedge clk);
                ready_mode = 0;
            end
        join_none
        send_beat(8'h34, 0, 1, 1, 1);
        idle(3);

        // mode flips mid-frame
        send_beat(8'h10, 0, 0, 1, 0);
        send_beat(8'h21, 1, 0, 0, 0);
        send_beat(8'h03, 0, 1, 1, 1);
        idle(2);

        // reset mid-frame drops the pre-reset beats
        send_beat(8'h55, 1, 1, 1, 0);
        send_beat(8'h66, 0, 0, 1, 0);
        do_reset();
        send_beat(8'h07, 0, 0, 1, 1);
        idle(2);

        // randomized frames with random downstream back-pressure
        ready_mode = 1;
        for (int f = 0; f < 60; f++) begin
            int mode;
            int nb;
            mode = int'($urandom_range(0, 1));
            nb   = int'($urandom_range(1, 10));
            for (int b = 0; b < nb; b++) begin
                int m;
                int last;
                m    = ($urandom_range(0, 19) == 0) ? 1 - mode : mode;
                last = (b == nb - 1 && $urandom_range(0, 3) != 0) ? 1 : 0;
                send_beat(int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 1)), m, last);
                if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
            end
            if ($urandom_range(0, 29) == 0) do_reset();
        end

        ready_mode = 0;
        idle(1);
        for (int t = 0; t < 50 && (q16.size() != 0 || q10.size() != 0); t++) idle(1);
        check("drain_q16", q16.size(), 0);
        check("drain_q10", q10.size(), 0);
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
